fetch_stage: RTL and testbench

//  IF stage feeding ID: owns PC, next-PC mux driven by PCSrc/ID_Flush from the ID-stage jump unit,

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 18 +
 rtl/fetch_stage_next_pc_mux.sv | 28 ++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared IF-stage definitions: PC-source codes used by the jump unit,
// fetch FSM encodings and the IF/ID bundle.
package fetch_stage_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_J   = 2'd2;
  localparam logic [1:0] PCSRC_JR  = 2'd3;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus: req/addr out of IF,
// ready/rdata back from memory.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req, addr,
    input  ready, rdata
  );

  modport slave (
    input  req, addr,
    output ready, rdata
  );
endinterface

// File: rtl/fetch_stage_next_pc_mux.sv
// Redirect target select: pc_src picks pc+4/branch/jump/jr,
// low two bits forced to zero (word-aligned fetch).
module next_pc_mux
  import fetch_stage_pkg::*;
(
  input  logic [1:0]  i_pc_src,
  input  logic [31:0] i_pc4,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_target
);

  logic [31:0] w_sel;

  always_comb begin
    w_sel = i_pc4;
    unique case (1'b1)
      (i_pc_src == PCSRC_SEQ): w_sel = i_pc4;
      (i_pc_src == PCSRC_BR):  w_sel = i_branch_target;
      (i_pc_src == PCSRC_J):   w_sel = i_jump_target;
      (i_pc_src == PCSRC_JR):  w_sel = i_jr_target;
    endcase
  end

  assign o_target = w_sel & ~32'h3;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, redirect handling, imem handshake with skid + drop,
// IF/ID register. Ports: clk/rst_n, hazard/jump inputs, imem bus, IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_stall,
  input  logic [1:0]    i_pc_src,
  input  logic          i_id_flush,
  input  logic [31:0]   i_branch_target,
  input  logic [31:0]   i_jump_target,
  input  logic [31:0]   i_jr_target,
  fetch_stage_if.master imem,
  output logic          o_ifid_valid,
  output logic [31:0]   o_ifid_instr,
  output logic [31:0]   o_ifid_pc4
);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_skid;
  logic [31:0] w_skid_nxt;
  logic [31:0] r_drop_addr;
  logic [31:0] w_drop_nxt;
  if_id_t      r_ifid;
  if_id_t      w_ifid_nxt;
  logic [31:0] w_pc4;
  logic [31:0] w_target;
  logic        w_redirect;

  assign w_pc4      = r_pc + 32'd4;
  assign w_redirect = (i_pc_src != PCSRC_SEQ) & ~i_stall;

  next_pc_mux u_next_pc_mux (
    .i_pc_src        (i_pc_src),
    .i_pc4           (w_pc4),
    .i_branch_target (i_branch_target),
    .i_jump_target   (i_jump_target),
    .i_jr_target     (i_jr_target),
    .o_target        (w_target)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_skid_nxt  = r_skid;
    w_drop_nxt  = r_drop_addr;
    w_ifid_nxt  = r_ifid;
    // Unstalled IF/ID becomes a bubble unless a real
    // instruction is loaded below.
    if (!i_stall) begin
      w_ifid_nxt.valid = 1'b0;
      w_ifid_nxt.instr = NOP_INSTR;
    end
    case (r_state)
      ST_FETCH: begin
        if (i_stall) begin
          if (imem.ready) begin
            w_skid_nxt  = imem.rdata;
            w_state_nxt = ST_HOLD;
          end
        end else if (w_redirect) begin
          w_pc_nxt = w_target;
          // Request still open: remember its address so it
          // can be completed and thrown away.
          if (!imem.ready) begin
            w_drop_nxt  = r_pc;
            w_state_nxt = ST_DROP;
          end
        end else if (imem.ready) begin
          w_pc_nxt = w_pc4;
          if (!i_id_flush)
            w_ifid_nxt = '{1'b1, imem.rdata, w_pc4};
        end
      end
      ST_HOLD: begin
        if (!i_stall) begin
          w_state_nxt = ST_FETCH;
          if (w_redirect) begin
            w_pc_nxt = w_target;
          end else begin
            w_pc_nxt = w_pc4;
            if (!i_id_flush)
              w_ifid_nxt = '{1'b1, r_skid, w_pc4};
          end
        end
      end
      ST_DROP: begin
        if (imem.ready)
          w_state_nxt = ST_FETCH;
        if (w_redirect)
          w_pc_nxt = w_target;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_skid      <= 32'h0;
      r_drop_addr <= 32'h0;
      r_ifid      <= '{1'b0, NOP_INSTR, 32'h0};
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_skid      <= w_skid_nxt;
      r_drop_addr <= w_drop_nxt;
      r_ifid      <= w_ifid_nxt;
    end
  end

  assign imem.req  = (r_state != ST_HOLD);
  assign imem.addr = (r_state == ST_DROP) ? r_drop_addr : r_pc;

  assign o_ifid_valid = r_ifid.valid;
  assign o_ifid_instr = r_ifid.instr;
  assign o_ifid_pc4   = r_ifid.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addr^0xDEAD0000,
// wait states / stalls / redirects / reset driven cycle by cycle.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [1:0]  pc_src;
  logic        id_flush;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;

  int n_chk = 0;
  int n_bad = 0;

  fetch_stage_if bus ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign bus.rdata = mem_word(bus.addr);

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_stall         (stall),
    .i_pc_src        (pc_src),
    .i_id_flush      (id_flush),
    .i_branch_target (br_tgt),
    .i_jump_target   (j_tgt),
    .i_jr_target     (jr_tgt),
    .imem            (bus),
    .o_ifid_valid    (ifid_valid),
    .o_ifid_instr    (ifid_instr),
    .o_ifid_pc4      (ifid_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic rdy, input logic stl,
                     input logic [1:0] src, input logic fl);
    bus.ready = rdy;
    stall     = stl;
    pc_src    = src;
    id_flush  = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    stall     = 1'b0;
    pc_src    = PCSRC_SEQ;
    id_flush  = 1'b0;
    br_tgt    = 32'h0;
    j_tgt     = 32'h0;
    jr_tgt    = 32'h0;
    bus.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pc4", ifid_pc4, 32'h0);
    check("rst_addr", bus.addr, 32'h0);
    #2 rst_n = 1'b1;
    #1;
    check("req_on", {31'h0, bus.req}, 32'h1);

    // zero-wait streaming
    cyc(1, 0, PCSRC_SEQ, 0);
    check("s0_valid", {31'h0, ifid_valid}, 32'h1);
    check("s0_instr", ifid_instr, 32'hDEAD_0000);
    check("s0_pc4", ifid_pc4, 32'h4);
    check("s0_addr", bus.addr, 32'h4);
    cyc(1, 0, PCSRC_SEQ, 0);
    check("s1_pc4", ifid_pc4, 32'h8);
    check("s1_addr", bus.addr, 32'h8);
    cyc(1, 0, PCSRC_SEQ, 0);
    check("s2_pc4", ifid_pc4, 32'hC);
    cyc(1, 0, PCSRC_SEQ, 0);
    check("s3_addr", bus.addr, 32'h10);

    // three wait states at 0x10
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, PCSRC_SEQ, 0);
      check("ws_addr", bus.addr, 32'h10);
      check("ws_bubble", {31'h0, ifid_valid}, 32'h0);
    end
    cyc(1, 0, PCSRC_SEQ, 0);
    check("ws_valid", {31'h0, ifid_valid}, 32'h1);
    check("ws_pc4", ifid_pc4, 32'h14);
    check("ws_instr", ifid_instr, 32'hDEAD_0010);
    repeat (3) cyc(1, 0, PCSRC_SEQ, 0);
    check("pre_hold_addr", bus.addr, 32'h20);

    // stall on the ready cycle -> skid / HOLD
    cyc(1, 1, PCSRC_SEQ, 0);
    check("hold_req", {31'h0, bus.req}, 32'h0);
    check("hold_pc4", ifid_pc4, 32'h20);
    cyc(0, 1, PCSRC_BR, 0);
    check("hold2_req", {31'h0, bus.req}, 32'h0);
    cyc(0, 0, PCSRC_SEQ, 0);
    check("skid_instr", ifid_instr, 32'hDEAD_0020);
    check("skid_pc4", ifid_pc4, 32'h24);
    check("skid_addr", bus.addr, 32'h24);
    repeat (3) cyc(1, 0, PCSRC_SEQ, 0);
    check("pre_drop_addr", bus.addr, 32'h30);

    // branch while 0x30 outstanding -> DROP
    br_tgt = 32'h100;
    cyc(0, 0, PCSRC_BR, 0);
    check("drop_addr", bus.addr, 32'h30);
    check("drop_req", {31'h0, bus.req}, 32'h1);
    check("drop_bubble", {31'h0, ifid_valid}, 32'h0);
    cyc(1, 0, PCSRC_SEQ, 0);
    check("drop_discard", {31'h0, ifid_valid}, 32'h0);
    check("br_addr", bus.addr, 32'h100);
    cyc(1, 0, PCSRC_SEQ, 0);
    check("br_pc4", ifid_pc4, 32'h104);
    check("br_instr", ifid_instr, 32'hDEAD_0100);

    // JR under stall is ignored, then taken with aligned target
    jr_tgt = 32'h203;
    cyc(0, 1, PCSRC_JR, 0);
    check("jr_stall_addr", bus.addr, 32'h104);
    check("jr_stall_hold", ifid_pc4, 32'h104);
    cyc(1, 0, PCSRC_JR, 0);
    check("jr_addr", bus.addr, 32'h200);
    check("jr_bubble", {31'h0, ifid_valid}, 32'h0);
    cyc(1, 0, PCSRC_SEQ, 0);
    check("jr_valid", {31'h0, ifid_valid}, 32'h1);
    check("jr_pc4", ifid_pc4, 32'h204);

    // PC wrap at top of address space
    j_tgt = 32'hFFFF_FFFC;
    cyc(1, 0, PCSRC_J, 0);
    check("j_addr", bus.addr, 32'hFFFF_FFFC);
    cyc(1, 0, PCSRC_SEQ, 0);
    check("wrap_pc4", ifid_pc4, 32'h0);
    check("wrap_addr", bus.addr, 32'h0);

    // flush with sequential PC: bubble only
    cyc(1, 0, PCSRC_SEQ, 1);
    check("flush_bubble", {31'h0, ifid_valid}, 32'h0);
    check("flush_addr", bus.addr, 32'h4);

    // async reset while in DROP
    j_tgt = 32'h300;
    cyc(0, 0, PCSRC_J, 0);
    check("drop2_addr", bus.addr, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'h0, ifid_valid}, 32'h0);
    check("arst_instr", ifid_instr, 32'h0);
    check("arst_pc4", ifid_pc4, 32'h0);
    check("arst_addr", bus.addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, PCSRC_SEQ, 0);
    check("post_valid", {31'h0, ifid_valid}, 32'h1);
    check("post_pc4", ifid_pc4, 32'h4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
